resp_checker: RTL

RESP_CHECKER -- requirements
Module: resp_checker

---
 rtl/resp_chk_pkg.sv | 30 +++
 rtl/resp_fifo.sv | 70 +++++++
 rtl/resp_checker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/resp_chk_pkg.sv
// Shared definitions for the response checker.
//   state_e : checker FSM states (IDLE / WAIT / CHECK)
//   CNT_W   : width of the pass/fail statistics counters
//   DLY_W   : width of the per-expectation sampling delay
//   CNT_MAX : saturation value of the statistics counters
//   sat_inc : saturating increment used by both counters
package resp_chk_pkg;

  localparam int CNT_W = 16;
  localparam int DLY_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Counters stick at CNT_MAX instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Expectation FIFO for the response checker.
//   clk, rst_n : clock and synchronous active-low reset (clears pointers)
//   push, push_data : write request (ignored while full)
//   pop, pop_data   : read request (ignored while empty), head-of-queue data
//   full, empty     : status, derived from the registered pointers only
// DEPTH must be a power of two, 2 or more.
module resp_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointers; they wrap naturally through the extra MSB.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/resp_checker.sv
// Response checker: queues (value, delay) expectations, waits delay+1 cycles
// after taking one, then compares dut_z against the expected value for one cycle.
//   clk, rst_n            : clock and synchronous active-low reset
//   exp_valid/exp_ready   : expectation handshake (ready = FIFO not full)
//   exp_value, exp_delay  : expected response and cycles to wait before sampling
//   dut_z                 : response under check
//   pass_cnt, fail_cnt    : saturating match / mismatch counters
//   first_fail            : dut_z captured at the first mismatch
//   err                   : sticky mismatch flag
//   idle                  : FIFO empty and FSM in IDLE
module resp_checker
  import resp_chk_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [W-1:0]     exp_value,
  input  logic [DLY_W-1:0] exp_delay,
  input  logic [W-1:0]     dut_z,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [W-1:0]     first_fail,
  output logic             err,
  output logic             idle
);

  logic [W+DLY_W-1:0] fifo_rdata;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;

  state_e             state_q, state_d;
  logic [W-1:0]       value_q, value_d;
  logic [DLY_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [W-1:0]       first_fail_q, first_fail_d;
  logic               err_q, err_d;

  resp_fifo #(
    .DW    (W + DLY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (exp_valid),
    .push_data ({exp_value, exp_delay}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM, wait counter and statistics next-state logic.
  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    wait_cnt_d   = wait_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    err_d        = err_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          value_d    = fifo_rdata[W+DLY_W-1:DLY_W];
          wait_cnt_d = fifo_rdata[DLY_W-1:0];
          state_d    = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // The zero-count cycle is itself spent in WAIT, so delay 0 still costs one cycle.
        if (wait_cnt_q == 8'd0) begin
          state_d = CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      CHECK: begin
        if (dut_z == value_q) begin
          pass_cnt_d = sat_inc(pass_cnt_q);
        end else begin
          fail_cnt_d = sat_inc(fail_cnt_q);
          err_d      = 1'b1;
          if (!err_q) begin
            first_fail_d = dut_z;
          end else begin
            first_fail_d = first_fail_q;
          end
        end
        // Chain straight into the next expectation to keep delay+2 throughput.
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          value_d    = fifo_rdata[W+DLY_W-1:DLY_W];
          wait_cnt_d = fifo_rdata[DLY_W-1:0];
          state_d    = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      value_q      <= {W{1'b0}};
      wait_cnt_q   <= {DLY_W{1'b0}};
      pass_cnt_q   <= {CNT_W{1'b0}};
      fail_cnt_q   <= {CNT_W{1'b0}};
      first_fail_q <= {W{1'b0}};
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      wait_cnt_q   <= wait_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      err_q        <= err_d;
    end
  end

  assign exp_ready  = !fifo_full;
  assign idle       = fifo_empty && (state_q == IDLE);
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;
  assign err        = err_q;

endmodule
